// File: rtl/riscv_trace_capture.sv
// Passive commit-trace monitor: captures one record per PC change into a FIFO and streams framed bytes.
// Optional trailing XOR checksum byte per frame when TRACE_CKSUM_EN is defined.
module riscv_trace_capture #(
  parameter int          DEPTH = 8,
  parameter logic [7:0]  HDR   = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [63:0]              pc_in,
  input  logic [31:0]              instr_in,
  input  logic [63:0]              result_in,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef TRACE_CKSUM_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_BODY = 2'd2, S_CKS = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_BODY = 2'd2} state_t;
`endif

  // Records are stored in wire order: byte k of the body sits at bits [8k+7:8k].
  logic [159:0]  mem_q [DEPTH];
  logic [159:0]  rec;

  logic [63:0]   pc_last_q, pc_last_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  state_t        state_q, state_d;
  logic [159:0]  shreg_q, shreg_d;
  logic [4:0]    idx_q, idx_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
`ifdef TRACE_CKSUM_EN
  logic [7:0]    cks_q, cks_d;
`endif

  logic rec_new, full, pop, push, drop, hs;

  assign rec = {result_in, instr_in, pc_in};

  always_comb begin
    rec_new    = enable && (pc_in != pc_last_q);
    full       = (count_q == CW'(DEPTH));
    pop        = (state_q == S_IDLE) && (count_q != '0);
    // A full FIFO still takes the record when the serializer frees a slot this cycle.
    push       = rec_new && (!full || pop);
    drop       = rec_new && full && !pop;
    pc_last_d  = rec_new ? pc_in : pc_last_q;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | drop;
    drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_comb begin
    hs         = tx_valid_q && tx_ready;
    state_d    = state_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
`ifdef TRACE_CKSUM_EN
    cks_d      = cks_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shreg_d    = mem_q[rd_ptr_q];
          state_d    = S_HDR;
          tx_valid_d = 1'b1;
          tx_data_d  = HDR;
`ifdef TRACE_CKSUM_EN
          cks_d      = HDR;
`endif
        end
      end
      S_HDR: begin
        if (hs) begin
          state_d   = S_BODY;
          idx_d     = 5'd0;
          tx_data_d = shreg_q[7:0];
          shreg_d   = shreg_q >> 8;
        end
      end
      S_BODY: begin
        if (hs) begin
`ifdef TRACE_CKSUM_EN
          cks_d = cks_q ^ tx_data_q;
`endif
          if (idx_q == 5'd19) begin
`ifdef TRACE_CKSUM_EN
            state_d   = S_CKS;
            tx_data_d = cks_q ^ tx_data_q;
`else
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
`endif
          end else begin
            idx_d     = idx_q + 5'd1;
            tx_data_d = shreg_q[7:0];
            shreg_d   = shreg_q >> 8;
          end
        end
      end
`ifdef TRACE_CKSUM_EN
      S_CKS: begin
        if (hs) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
        end
      end
`endif
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_last_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'h0000;
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      idx_q      <= 5'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
`ifdef TRACE_CKSUM_EN
      cks_q      <= 8'h00;
`endif
    end else begin
      pc_last_q  <= pc_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
`ifdef TRACE_CKSUM_EN
      cks_q      <= cks_d;
`endif
    end
  end

  // Handshake: a byte transfers at a rising edge where tx_valid && tx_ready; tx_data/tx_valid hold while stalled.
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
  assign fifo_count = count_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/riscv_trace_capture.md
# riscv_trace_capture

- Passive commit-trace monitor that sits beside the `riscv` core and consumes its debug outputs (`PC_Output`, `Instruction`, `Result`).
- Captures one record per PC change into a record FIFO and serializes records as framed bytes over a ready/valid byte stream.
- Lets a bench, or an on-board UART, read back the execution trace without probing internal nets.

## Interface
Parameters:
- `DEPTH`, 8, record FIFO depth in records (power of two, 2..64)
- `HDR`, 8'hA5, frame header byte

Ports:
- `clk`  input  1  system clock, shared with the core
- `reset`  input  1  reset, asynchronous, active-high
- `enable`  input  1  capture enable; low = no new records, drain continues
- `pc_in`  input  64  core `PC_Output`
- `instr_in`  input  32  core `Instruction`
- `result_in`  input  64  core `Result`
- `tx_data`  output  8  stream byte
- `tx_valid`  output  1  `tx_data` valid
- `tx_ready`  input  1  downstream accepts byte
- `overflow`  output  1  sticky: at least one record dropped since reset
- `drop_cnt`  output  16  dropped-record count, saturates at 16'hFFFF
- `fifo_count`  output  $clog2(DEPTH)+1  records held

## Operation
Capture:
- `pc_last` register, reset 64'hFFFF_FFFF_FFFF_FFFF.
- At each rising edge with `enable`=1 and `pc_in != pc_last`: form record {pc_in, instr_in, result_in} (160 bits) and push; `pc_last <= pc_in`.
- `pc_last` updates only when `enable`=1. A record is still formed when the FIFO is full, but it is dropped.
- Full FIFO with no pop in the same cycle: drop the record, set `overflow`, increment `drop_cnt` (saturating).
- Full FIFO with a pop in the same cycle: accept the push.

Serializer FSM, with states IDLE, HDR, BODY, and CKS (CKS only with the macro):
- IDLE: if FIFO non-empty, pop into `shreg` and go to HDR.
- HDR: `tx_data`=`HDR`. On handshake go to BODY with `idx`=0.
- BODY: `tx_data` = byte `idx` of the record. Byte order: PC bytes 0..7 little-endian, then instr bytes 8..11 LE, then result bytes 12..19 LE.
  - On handshake, `idx`++.
  - After `idx`=19 is accepted, go to CKS (macro defined) or IDLE.
- CKS: `tx_data` = XOR of `HDR` and all 20 body bytes. On handshake go to IDLE.
- Handshake is `tx_valid && tx_ready` at a rising edge. `tx_valid`=1 in HDR, BODY, and CKS; 0 in IDLE.
- `tx_data` and `tx_valid` are held stable while `tx_valid && !tx_ready`.
- `enable` going low mid-frame does not abort the frame.

Reset:
- Any assertion, including mid-frame, immediately clears FIFO pointers, `fifo_count`=0, state=IDLE, `tx_valid`=0, `tx_data`=8'h00, `overflow`=0, `drop_cnt`=0, and `pc_last`=all-ones.
- A partial frame is discarded. No resumption.

## Timing
- Capture latency: the PC change is sampled at edge N. The record is in the FIFO after edge N, and `fifo_count` reflects it in cycle N+1.
- IDLE with FIFO non-empty at edge M: pop at M, `tx_valid`=1 with the header during cycle M+1.
- Best-case frame length with `tx_ready` held at 1: 21 cycles, or 22 with the checksum. Plus 1 IDLE cycle between frames, because IDLE always spends one cycle popping.
- Sustained PC changes every cycle overflow an 8-deep FIFO. This is expected; `overflow` reports it.
- Outputs are registered. There is no combinational path from `tx_ready` to `tx_data`. `tx_valid` changes only at edges.

## Configuration
- `TRACE_CKSUM_EN` defined: the CKS state exists and each frame ends with the XOR checksum byte (22 bytes per frame).
- `TRACE_CKSUM_EN` undefined: CKS state and checksum logic are absent. Frame is 21 bytes; BODY returns directly to IDLE.

## Test plan
- Reset then hold: `reset`=1 for 2 cycles, then 0 with `enable`=0 -> `tx_valid`=0, `fifo_count`=0, `overflow`=0, `drop_cnt`=0.
- Single record:
  - Stimulus: `enable`=1, pc_in=64'h0, instr_in=32'h00500093, result_in=64'h5, `tx_ready`=1.
  - Required response: bytes A5, 00×8, 93 00 50 00, 05 00×7.
  - With `TRACE_CKSUM_EN`: trailing byte = 8'h63 (A5^93^50^05).
- Backpressure: toggle `tx_ready` 1/0 every cycle during a frame -> no byte lost or duplicated, `tx_data` stable while stalled, frame identical to the unstalled case.
- Overflow: `tx_ready`=0, PC changes on 10 consecutive cycles with DEPTH=8 -> `fifo_count`=8, `drop_cnt`=1, `overflow`=1. One record is in `shreg` and one is dropped; the FIFO holds PCs 1..8.
- Repeated PC: `pc_in` held at 64'h10 for 5 cycles -> exactly one record captured.
- Reset mid-frame: assert `reset` after the 7th byte -> `tx_valid`=0 immediately. After release with a new PC, the next output starts with `HDR`.
